// File: rtl/axis_fifo_ingress_arb.sv
// Frame-aware round-robin arbiter feeding a single FIFO write port, with high-water grant throttling.
// Define AXIS_ARB_MAX_BEATS_EN to truncate frames at MAX_BEATS beats and drain the remainder.
module axis_fifo_ingress_arb #(
  parameter int S_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
  parameter int USER_WIDTH  = 1,
  parameter int DEPTH_WIDTH = 14,
  parameter int HIGH_WATER  = 8192,
  parameter int MAX_BEATS   = 1024
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]      s_axis_tkeep,
  input  logic [S_COUNT-1:0]                 s_axis_tvalid,
  output logic [S_COUNT-1:0]                 s_axis_tready,
  input  logic [S_COUNT-1:0]                 s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0]      s_axis_tuser,
  output logic [DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]              m_axis_tkeep,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output logic [USER_WIDTH-1:0]              m_axis_tuser,
  input  logic [DEPTH_WIDTH-1:0]             fifo_depth,
  output logic [S_COUNT-1:0]                 grant,
  output logic [$clog2(S_COUNT)-1:0]         grant_index,
  output logic                               frame_done,
  output logic                               throttled
);
  // state | meaning
  // IDLE  | no grant; arbitrate when requests exist and FIFO is at or below HIGH_WATER
  // XFER  | granted stream muxed straight to the FIFO until its tlast handshake
  // DRAIN | (optional) frame truncated; discard source beats up to its own tlast

  localparam int IDX_W = $clog2(S_COUNT);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
`ifdef AXIS_ARB_MAX_BEATS_EN
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
`endif
  localparam logic [DEPTH_WIDTH-1:0] HIGH_WATER_D = DEPTH_WIDTH'(HIGH_WATER);

  if (S_COUNT < 2 || S_COUNT > 16) begin : g_chk_s_count
    $error("axis_fifo_ingress_arb: S_COUNT must be 2..16");
  end
  if (MAX_BEATS < 1) begin : g_chk_max_beats
    $error("axis_fifo_ingress_arb: MAX_BEATS must be at least 1");
  end

  logic [1:0]            state, state_nxt;
  logic [S_COUNT-1:0]    grant_nxt;
  logic [IDX_W-1:0]      grant_index_nxt;
  logic                  throttled_nxt;
  logic                  found;
  logic [IDX_W-1:0]      pick;
  logic [IDX_W:0]        cand;
  logic                  src_valid, src_last, forced_last;
  logic [DATA_WIDTH-1:0] src_data;
  logic [KEEP_WIDTH-1:0] src_keep;
  logic [USER_WIDTH-1:0] src_user;

  assign src_valid = s_axis_tvalid[grant_index];
  assign src_last  = s_axis_tlast[grant_index];
  assign src_data  = s_axis_tdata[grant_index*DATA_WIDTH +: DATA_WIDTH];
  assign src_keep  = s_axis_tkeep[grant_index*KEEP_WIDTH +: KEEP_WIDTH];
  assign src_user  = s_axis_tuser[grant_index*USER_WIDTH +: USER_WIDTH];

  // first requester strictly after the previous grant, wrapping modulo S_COUNT
  always_comb begin
    found = 1'b0;
    pick  = grant_index;
    cand  = '0;
    for (int k = 1; k <= S_COUNT; k++) begin
      cand = {1'b0, grant_index} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(S_COUNT)) cand = cand - (IDX_W+1)'(S_COUNT);
      if (!found && s_axis_tvalid[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDX_W-1:0];
      end
    end
  end

`ifdef AXIS_ARB_MAX_BEATS_EN
  logic [BEAT_W-1:0] beat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (state != ST_XFER) begin
      beat_cnt <= '0;
    end else if (src_valid && m_axis_tready) begin
      beat_cnt <= m_axis_tlast ? '0 : beat_cnt + BEAT_W'(1);
    end
  end

  assign forced_last = (state == ST_XFER) && (beat_cnt == BEAT_W'(MAX_BEATS - 1)) && !src_last;
`else
  assign forced_last = 1'b0;
`endif

  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    grant_index_nxt = grant_index;
    throttled_nxt   = 1'b0;
    s_axis_tready   = '0;
    m_axis_tvalid   = 1'b0;
    m_axis_tdata    = src_data;
    m_axis_tkeep    = (KEEP_ENABLE != 0) ? src_keep : '1;
    m_axis_tlast    = src_last | forced_last;
    m_axis_tuser    = src_user;
    m_axis_tuser[0] = src_user[0] | forced_last;
    frame_done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          if (fifo_depth > HIGH_WATER_D) begin
            throttled_nxt = 1'b1;
          end else begin
            grant_nxt       = S_COUNT'(1) << pick;
            grant_index_nxt = pick;
            state_nxt       = ST_XFER;
          end
        end
      end
      ST_XFER: begin
        m_axis_tvalid              = src_valid;
        s_axis_tready[grant_index] = m_axis_tready;
        if (src_valid && m_axis_tready && m_axis_tlast) begin
          frame_done = 1'b1;
          state_nxt  = ST_IDLE;
          grant_nxt  = '0;
`ifdef AXIS_ARB_MAX_BEATS_EN
          if (forced_last) begin
            state_nxt = ST_DRAIN;
            grant_nxt = grant;
          end
`endif
        end
      end
`ifdef AXIS_ARB_MAX_BEATS_EN
      ST_DRAIN: begin
        s_axis_tready[grant_index] = 1'b1;
        if (src_valid && src_last) begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
        end
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // grant_index resets to the top stream so stream 0 wins the first arbitration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      grant       <= '0;
      grant_index <= IDX_W'(S_COUNT - 1);
      throttled   <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      grant_index <= grant_index_nxt;
      throttled   <= throttled_nxt;
    end
  end
endmodule

// File: tb/tb_axis_fifo_ingress_arb.sv
// Self-checking bench for axis_fifo_ingress_arb: directed scenarios plus randomized traffic vs a frame-level model.
// Builds with or without AXIS_ARB_MAX_BEATS_EN.
module tb_axis_fifo_ingress_arb;
  localparam int S  = 4;
  localparam int HW = 8192;
`ifdef AXIS_ARB_MAX_BEATS_EN
  localparam int MAXB = 6;
`else
  localparam int MAXB = 1024;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [S*8-1:0] s_tdata;
  logic [S-1:0]  s_tkeep, s_tvalid, s_tready, s_tlast, s_tuser;
  logic [7:0]    m_tdata;
  logic          m_tkeep, m_tvalid, m_tready, m_tlast, m_tuser;
  logic [13:0]   depth;
  logic [S-1:0]  grant;
  logic [1:0]    grant_index;
  logic          frame_done, throttled;

  always #5 clk = ~clk;

  axis_fifo_ingress_arb #(
    .S_COUNT(S), .DATA_WIDTH(8), .KEEP_ENABLE(0), .KEEP_WIDTH(1), .USER_WIDTH(1),
    .DEPTH_WIDTH(14), .HIGH_WATER(HW), .MAX_BEATS(MAXB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .fifo_depth(depth), .grant(grant), .grant_index(grant_index),
    .frame_done(frame_done), .throttled(throttled)
  );

  int n_pass, n_total;
  logic [9:0] sq [S][$];   // per-stream pending beats: {user, last, data}
  logic [S-1:0] vld;
  logic rdy;
  int gap_pct, ready_mode, cyc;
  int done_log[$];
  int dut_done_cnt, dut_beats;

  // frame-level reference state
  bit m_busy, m_drain, exp_thr;
  int m_owner, m_last, m_nbeats, m_frames;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int rr_pick(input int last, input logic [S-1:0] v);
    for (int k = 1; k <= S; k++) begin
      if (v[(last + k) % S]) return (last + k) % S;
    end
    return -1;
  endfunction

  task automatic push_frame(input int s, input int len);
    for (int j = 0; j < len; j++)
      sq[s].push_back({1'($urandom), (j == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
  endtask

  task automatic drive();
    for (int i = 0; i < S; i++) begin
      logic [9:0] b;
      b = (sq[i].size() > 0) ? sq[i][0] : 10'($urandom);
      vld[i] = (sq[i].size() > 0) && ($urandom_range(99) >= gap_pct);
      s_tdata[i*8 +: 8] = b[7:0];
      s_tlast[i] = b[8];
      s_tuser[i] = b[9];
    end
    s_tvalid = vld;
    s_tkeep  = S'($urandom);
    case (ready_mode)
      0:       rdy = 1'b1;
      1:       rdy = (cyc % 2) == 0;
      default: rdy = $urandom_range(3) != 0;
    endcase
    m_tready = rdy;
  endtask

  task automatic cycle();
    logic exp_valid, exp_last, exp_user, forced, hs_m, hs_d, exp_done;
    logic [7:0] exp_data;
    logic [S-1:0] exp_grant, exp_ready;
    logic [9:0] b;
    int p;
    drive();
    #1;
    exp_valid = 0; exp_last = 0; exp_user = 0; forced = 0; exp_data = '0;
    exp_grant = '0; exp_ready = '0; b = '0;
    if (m_busy) begin
      exp_grant = S'(1) << m_owner;
      if (sq[m_owner].size() > 0) b = sq[m_owner][0];
      if (m_drain) begin
        exp_ready = exp_grant;
      end else begin
        exp_valid = vld[m_owner];
        exp_ready = rdy ? exp_grant : '0;
        exp_data  = b[7:0];
        exp_last  = b[8];
        exp_user  = b[9];
`ifdef AXIS_ARB_MAX_BEATS_EN
        if (m_nbeats == MAXB - 1 && !b[8]) begin
          forced = 1; exp_last = 1; exp_user = 1;
        end
`endif
      end
    end
    hs_m = m_busy && !m_drain && vld[m_owner] && rdy;
    hs_d = m_busy && m_drain && vld[m_owner];
    exp_done = hs_m && exp_last;

    chk("m_tvalid", m_tvalid, exp_valid);
    chk("grant", grant, exp_grant);
    chk("grant_index", grant_index, m_last);
    chk("s_tready", s_tready, exp_ready);
    chk("throttled", throttled, exp_thr);
    chk("frame_done", frame_done, exp_done);
    if (exp_valid) begin
      chk("m_tdata", m_tdata, exp_data);
      chk("m_tlast", m_tlast, exp_last);
      chk("m_tuser", m_tuser, exp_user);
      chk("m_tkeep", m_tkeep, 1);
    end
    if (frame_done) begin
      dut_done_cnt++;
      done_log.push_back(int'(grant_index));
    end
    if (m_tvalid && m_tready) dut_beats++;

    @(posedge clk);
    if (m_busy) begin
      exp_thr = 0;
      if (hs_m) begin
        b = sq[m_owner].pop_front();
        m_nbeats++;
        if (exp_last) begin
          m_nbeats = 0;
          m_frames++;
          if (forced) m_drain = 1;
          else m_busy = 0;
        end
      end else if (hs_d) begin
        b = sq[m_owner].pop_front();
        if (b[8]) begin
          m_busy = 0;
          m_drain = 0;
        end
      end
    end else if (vld != '0) begin
      if (depth > 14'(HW)) begin
        exp_thr = 1;
      end else begin
        exp_thr = 0;
        p = rr_pick(m_last, vld);
        m_owner = p; m_last = p; m_busy = 1; m_nbeats = 0;
      end
    end else begin
      exp_thr = 0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_throttled", throttled, 0);
    chk("rst_grant_index", grant_index, S - 1);
    for (int i = 0; i < S; i++) sq[i].delete();
    s_tvalid = '0;
    m_tready = 1'b0;
    m_busy = 0; m_drain = 0; exp_thr = 0; m_owner = 0; m_last = S - 1; m_nbeats = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic bit pending();
    bit any;
    any = m_busy;
    for (int i = 0; i < S; i++) if (sq[i].size() > 0) any = 1;
    return any;
  endfunction

  task automatic run_idle(input int max);
    int n;
    n = 0;
    while (pending() && n < max) begin
      cycle();
      n++;
    end
    chk("idle_timeout", n < max, 1);
    cycle();
  endtask

  initial begin
    int n, b0;
    n_pass = 0; n_total = 0; cyc = 0; gap_pct = 0; ready_mode = 0;
    dut_done_cnt = 0; dut_beats = 0; m_frames = 0;
    depth = '0; s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tuser = '0;
    m_tready = 1'b0; vld = '0; rdy = 1'b0;
    @(negedge clk);
    do_reset();

    // two frames on streams 0 and 2
    done_log.delete();
    push_frame(0, 3);
    push_frame(2, 3);
    run_idle(40);
    chk("t1_frames", done_log.size(), 2);
    chk("t1_first", done_log[0], 0);
    chk("t1_second", done_log[1], 2);

    // all streams requesting: strict rotation
    do_reset();
    done_log.delete();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < S; i++) push_frame(i, 2);
    run_idle(80);
    chk("t2_frames", done_log.size(), 8);
    for (int k = 0; k < 8; k++) chk("t2_rotation", done_log[k], k % S);

    // throttle boundary
    do_reset();
    depth = 14'd8193;
    push_frame(1, 2);
    repeat (20) cycle();
    chk("t3_throttled", throttled, 1);
    chk("t3_no_grant", grant, 0);
    depth = 14'd8192;
    cycle();
    chk("t3_grant", grant, 4'b0010);
    run_idle(20);
    chk("t3_unthrottled", throttled, 0);

    // toggling backpressure; depth above threshold mid-frame does not stall
    do_reset();
    depth = '0;
    ready_mode = 1;
    b0 = dut_beats;
    push_frame(3, 6);
    repeat (4) cycle();
    depth = 14'd9000;
    run_idle(40);
    chk("t4_beats", dut_beats - b0, 6);
    ready_mode = 0;
    depth = '0;

    // reset mid-frame abandons it; stream 0 first afterwards
    do_reset();
    push_frame(1, 5);
    n = 0;
    while (sq[1].size() > 3 && n < 20) begin
      cycle();
      n++;
    end
    chk("t5_progress", n < 20, 1);
    do_reset();
    done_log.delete();
    push_frame(3, 2);
    push_frame(1, 2);
    push_frame(0, 2);
    run_idle(40);
    chk("t5_frames", done_log.size(), 3);
    chk("t5_first", done_log[0], 0);
    chk("t5_second", done_log[1], 1);

    // long frame: truncated and drained when the limit is built in
    do_reset();
    b0 = dut_beats;
    n = dut_done_cnt;
    push_frame(2, 9);
    run_idle(60);
`ifdef AXIS_ARB_MAX_BEATS_EN
    chk("t6_beats", dut_beats - b0, 6);
`else
    chk("t6_beats", dut_beats - b0, 9);
`endif
    chk("t6_done", dut_done_cnt - n, 1);

    // randomized traffic
    do_reset();
    gap_pct = 20;
    ready_mode = 2;
    n = dut_done_cnt;
    m_frames = 0;
    for (int c = 0; c < 400; c++) begin
      int s;
      s = $urandom_range(S - 1);
      if ($urandom_range(3) == 0 && sq[s].size() < 20) push_frame(s, $urandom_range(9, 1));
      depth = ($urandom_range(9) == 0) ? 14'($urandom_range(9000, 8193)) : 14'($urandom_range(8192));
      cycle();
    end
    gap_pct = 0;
    ready_mode = 0;
    depth = '0;
    run_idle(400);
    chk("t7_frame_count", dut_done_cnt - n, m_frames);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/axis_fifo_ingress_arb.md
Name: axis_fifo_ingress_arb

Overview:
- Frame-aware round-robin arbiter that shares the single input of an async FIFO / width-adapter instance between S_COUNT AXI-stream requesters.
- Grants one whole frame at a time and never interleaves beats of different frames.
- Throttles new grants using the FIFO's write-side depth status (s_status_depth) against a high-water threshold, so frames are not started into a nearly full FIFO.
- Sits in the write clock domain, directly upstream of the FIFO.

Parameters:
- S_COUNT, 4, number of requesting input streams (2..16).
- DATA_WIDTH, 8, tdata width per stream.
- KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep; when 0, m_axis_tkeep is driven all-ones.
- KEEP_WIDTH, ((DATA_WIDTH+7)/8), tkeep width.
- USER_WIDTH, 1, tuser width.
- DEPTH_WIDTH, 14, width of the fifo_depth input (must equal $clog2(FIFO DEPTH)+1).
- HIGH_WATER, 8192, no new grant is issued while fifo_depth > HIGH_WATER.
- MAX_BEATS, 1024, frame length limit in beats; used only with the optional feature.

Ports:
- clk  in  1  write-domain clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  packed input data, stream i at [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  packed input keep.
- s_axis_tvalid  in  S_COUNT  per-stream valid.
- s_axis_tready  out  S_COUNT  per-stream ready.
- s_axis_tlast  in  S_COUNT  per-stream last.
- s_axis_tuser  in  S_COUNT*USER_WIDTH  packed input user.
- m_axis_tdata  out  DATA_WIDTH  to FIFO input.
- m_axis_tkeep  out  KEEP_WIDTH  to FIFO input.
- m_axis_tvalid  out  1  to FIFO input.
- m_axis_tready  in  1  from FIFO input.
- m_axis_tlast  out  1  to FIFO input.
- m_axis_tuser  out  USER_WIDTH  to FIFO input.
- fifo_depth  in  DEPTH_WIDTH  FIFO s_status_depth, same clock domain.
- grant  out  S_COUNT  one-hot active grant, 0 when idle.
- grant_index  out  $clog2(S_COUNT)  index of the last or current grant.
- frame_done  out  1  one-cycle pulse on the tlast handshake of a granted frame.
- throttled  out  1  high while requests are pending but blocked by HIGH_WATER.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; grant=0; s_axis_tready=0; m_axis_tvalid=0; frame_done=0; throttled=0.
  - grant_index=S_COUNT-1, so stream 0 has first priority after reset.
  - Reset asserted mid-frame abandons the frame immediately. No tlast is emitted; the downstream FIFO is reset alongside.
- IDLE:
  - req = s_axis_tvalid.
  - If req!=0 and fifo_depth<=HIGH_WATER: pick the first requester searching upward from grant_index+1 (modulo S_COUNT), register grant and grant_index, go to XFER.
  - If req!=0 and fifo_depth>HIGH_WATER: throttled=1 and stay in IDLE.
  - All outputs are quiet in IDLE: m_axis_tvalid=0 and s_axis_tready=0.
- XFER:
  - Combinational mux of the selected stream: m_axis_* = s_axis_*[sel]; s_axis_tready[sel]=m_axis_tready; all other tready bits are 0.
  - fifo_depth is ignored while in XFER. Frames already granted are never stalled by the threshold; only FIFO tready backpressure applies.
  - On m_axis_tvalid & m_axis_tready & m_axis_tlast: frame_done pulses for 1 cycle, grant clears, state returns to IDLE.
- Latency:
  - tvalid rising in cycle N (FIFO below threshold) gives grant in N+1; the first beat can transfer in N+1.
  - One dead cycle (IDLE) between consecutive frames.
- Fairness:
  - With all streams requesting, grants rotate 0,1,2,...,S_COUNT-1,0.
  - A lone requester is re-granted back-to-back.
- Threshold boundary: fifo_depth == HIGH_WATER still grants; HIGH_WATER+1 blocks.
- A requester that drops tvalid mid-frame holds the grant; m_axis_tvalid follows its tvalid.

Optional Feature:
- Macro: AXIS_ARB_MAX_BEATS_EN.
- When defined:
  - A beat counter per grant, width $clog2(MAX_BEATS+1), counts accepted beats.
  - On the MAX_BEATS-th accepted beat without source tlast, the arbiter forces m_axis_tlast=1 and OR's 1 into m_axis_tuser[0] (bad-frame marker), then enters state DRAIN.
  - DRAIN: s_axis_tready[sel]=1 and m_axis_tvalid=0, discarding beats until the source tlast handshake; then go to IDLE.
  - frame_done pulses on the forced tlast, not at the end of DRAIN.
- When not defined: no counter and no DRAIN state; frames of any length pass unmodified.

Test Plan:
- Reset, then streams 0 and 2 each present a 3-beat frame, m_axis_tready=1 -> grant=0001 and 3 beats with tlast on the 3rd, one idle cycle, then grant=0100 and 3 beats; frame_done pulses twice.
- All 4 streams continuously present 2-beat frames -> grant_index sequence 0,1,2,3,0; no interleaved beats.
- fifo_depth=8193 with stream 1 valid -> throttled=1, grant=0 for 20 cycles; set fifo_depth=8192 -> grant=0010 next cycle.
- Granted stream 3, m_axis_tready toggles 1/0 every cycle over a 6-beat frame -> 6 beats transferred in order; fifo_depth raised above HIGH_WATER mid-frame does not stall the frame.
- Assert rst_n=0 at beat 2 of a 5-beat frame -> grant=0, m_axis_tvalid=0 immediately; after release, stream 0 has priority.
- With AXIS_ARB_MAX_BEATS_EN and MAX_BEATS=4, send a 7-beat frame -> 4 beats out, the 4th with tlast=1 and tuser=1; 3 beats drained with m_axis_tvalid=0; then IDLE.
